mode_counter: RTL

Parametrised up/down counter that generalises the basic 4-bit free-running counter. Adds configurable width and modulo, synchronous load and clear, count enable, and three run modes (wrap, saturate, one-shot). Provides terminal-count and sticky overflow status. Serves as the general timing/event counter for later NAND-to-FPGA datapath and sequencing blocks.

---
 rtl/mode_counter_if.sv | 26 ++
 rtl/mode_counter.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/mode_counter_if.sv
// Control and status bundle for mode_counter: step/load/clear controls in, count and flags out.
// Master drives controls and observes status; slave is the counter itself.
interface mode_counter_if #(
    parameter int unsigned WIDTH = 4
);
    logic             en;
    logic             up;
    logic [1:0]       mode;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic             clr;
    logic [WIDTH-1:0] count;
    logic             tc;
    logic             ovf;
    logic             done;

    modport master (
        output en, up, mode, load, load_val, clr,
        input  count, tc, ovf, done
    );

    modport slave (
        input  en, up, mode, load, load_val, clr,
        output count, tc, ovf, done
    );
endinterface

// File: rtl/mode_counter.sv
// mode_counter: up/down counter over 0..MAX_VAL with wrap/saturate/one-shot modes, tc pulse, sticky ovf/done.
// Latency: count and flags register on the edge that samples the inputs; no combinational input-to-output path.
// Backpressure: none (en every cycle); COUNTER_PRESCALE_EN adds a step divider of PRESCALE enabled cycles.
module mode_counter #(
    parameter int unsigned      WIDTH    = 4,
    parameter logic [WIDTH-1:0] MAX_VAL  = {WIDTH{1'b1}},
    parameter logic [WIDTH-1:0] RST_VAL  = '0,
    parameter int unsigned      PRESCALE = 4
) (
    input logic           clk,
    input logic           rst,
    mode_counter_if.slave bus
);

    typedef enum logic {
        RUN  = 1'b0,
        HOLD = 1'b1
    } state_t;

    localparam logic [1:0] MODE_SAT     = 2'b01;
    localparam logic [1:0] MODE_ONESHOT = 2'b10;

    if (WIDTH < 1 || WIDTH > 32) begin : g_bad_width
        $error("mode_counter: WIDTH must be 1..32");
    end
    if (RST_VAL > MAX_VAL) begin : g_bad_rst_val
        $error("mode_counter: RST_VAL exceeds MAX_VAL");
    end
    if (PRESCALE < 1) begin : g_bad_prescale
        $error("mode_counter: PRESCALE must be >= 1");
    end

    state_t           state, state_nx;
    logic [WIDTH-1:0] count_q, count_nx;
    logic             tc_q, tc_nx;
    logic             ovf_q, ovf_nx;
    logic             done_q, done_nx;
    logic             step;
    logic             at_bound;
    logic [WIDTH-1:0] load_clamped;

`ifdef COUNTER_PRESCALE_EN
    localparam int unsigned  PW       = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);
    logic [PW-1:0] presc_q, presc_nx;
`endif

    assign load_clamped = (bus.load_val > MAX_VAL) ? MAX_VAL : bus.load_val;
    // Bound is checked before stepping so MAX_VAL = all-ones never overflows WIDTH.
    assign at_bound     = bus.up ? (count_q == MAX_VAL) : (count_q == '0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= RUN;
            count_q <= RST_VAL;
            tc_q    <= 1'b0;
            ovf_q   <= 1'b0;
            done_q  <= 1'b0;
`ifdef COUNTER_PRESCALE_EN
            presc_q <= '0;
`endif
        end else begin
            state   <= state_nx;
            count_q <= count_nx;
            tc_q    <= tc_nx;
            ovf_q   <= ovf_nx;
            done_q  <= done_nx;
`ifdef COUNTER_PRESCALE_EN
            presc_q <= presc_nx;
`endif
        end
    end

    always_comb begin
        state_nx = state;
        count_nx = count_q;
        tc_nx    = 1'b0;
        ovf_nx   = ovf_q;
        done_nx  = done_q;
        step     = 1'b0;
`ifdef COUNTER_PRESCALE_EN
        presc_nx = presc_q;
`endif

        if (bus.clr) begin
            count_nx = RST_VAL;
            ovf_nx   = 1'b0;
            done_nx  = 1'b0;
            state_nx = RUN;
`ifdef COUNTER_PRESCALE_EN
            presc_nx = '0;
`endif
        end else if (bus.load) begin
            count_nx = load_clamped;
            done_nx  = 1'b0;
            state_nx = RUN;
`ifdef COUNTER_PRESCALE_EN
            presc_nx = '0;
`endif
        end else if (bus.en && state == RUN) begin
`ifdef COUNTER_PRESCALE_EN
            if (presc_q == PRE_LAST) begin
                presc_nx = '0;
                step     = 1'b1;
            end else begin
                presc_nx = presc_q + PW'(1);
            end
`else
            step = 1'b1;
`endif
        end

        if (step) begin
            if (!at_bound) begin
                count_nx = bus.up ? count_q + WIDTH'(1) : count_q - WIDTH'(1);
            end else begin
                tc_nx = 1'b1;
                case (bus.mode)
                    MODE_SAT: begin
                        ovf_nx = 1'b1;
                    end
                    MODE_ONESHOT: begin
                        done_nx  = 1'b1;
                        state_nx = HOLD;
                    end
                    default: begin
                        ovf_nx   = 1'b1;
                        count_nx = bus.up ? '0 : MAX_VAL;
                    end
                endcase
            end
        end
    end

    assign bus.count = count_q;
    assign bus.tc    = tc_q;
    assign bus.ovf   = ovf_q;
    assign bus.done  = done_q;

endmodule
